// File: rtl/heard_word_packer.sv
// Packs up to three 10-bit heard(meth, v) entries into 32-bit host words, flushing partial words after an idle timeout.
// Optional counters stat_words / stat_stall are built when HEARD_PACKER_STATS_EN is defined.
module heard_word_packer #(
  parameter int METH_WIDTH = 6,
  parameter int V_WIDTH    = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic                  heard__ENA,
  output logic                  heard__RDY,
  input  logic [METH_WIDTH-1:0] heard_meth,
  input  logic [V_WIDTH-1:0]    heard_v,
  output logic                  word__ENA,
  input  logic                  word__RDY,
  output logic [31:0]           word_data
`ifdef HEARD_PACKER_STATS_EN
  ,
  output logic [15:0]           stat_words,
  output logic [15:0]           stat_stall
`endif
);

  localparam int IDLE_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT);

  if (METH_WIDTH + V_WIDTH != 10) begin : g_bad_entry_width
    $error("heard_word_packer: METH_WIDTH + V_WIDTH must equal 10");
  end

  logic [29:0]       acc;
  logic [1:0]        cnt;
  logic [IDLE_W-1:0] idle;
  logic              out_valid;
  logic [9:0]        entry;
  logic              accept;
  logic              flush;
  logic              transfer;

  assign entry      = {heard_meth, heard_v};
  assign heard__RDY = (cnt != 2'd3);
  assign accept     = heard__ENA && heard__RDY;
  assign word__ENA  = out_valid && word__RDY;

  // An entry landing on the timeout cycle wins: it clears idle and cancels the flush.
  assign flush    = (TIMEOUT != 0) && (cnt != 2'd0) && (idle == IDLE_MAX) && !accept;
  assign transfer = ((cnt == 2'd3) || flush) && (!out_valid || word__RDY);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      acc       <= '0;
      cnt       <= '0;
      idle      <= '0;
      out_valid <= 1'b0;
      word_data <= '0;
    end else begin
      if (transfer) begin
        word_data <= {cnt, acc};
        out_valid <= 1'b1;
        acc       <= '0;
        cnt       <= '0;
      end else begin
        if (word__ENA) out_valid <= 1'b0;
        if (accept) begin
          case (cnt)
            2'd0:    acc[9:0]   <= entry;
            2'd1:    acc[19:10] <= entry;
            2'd2:    acc[29:20] <= entry;
            default: ;
          endcase
          cnt <= cnt + 2'd1;
        end
      end

      if (transfer || accept)
        idle <= '0;
      else if ((cnt != 2'd0) && (cnt != 2'd3) && (idle != IDLE_MAX))
        idle <= idle + 1'b1;
    end
  end

`ifdef HEARD_PACKER_STATS_EN
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      stat_words <= '0;
      stat_stall <= '0;
    end else begin
      if (word__ENA) stat_words <= stat_words + 16'd1;
      if ((cnt == 2'd3) && out_valid && !word__RDY) stat_stall <= stat_stall + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_heard_word_packer.sv
// Directed self-checking bench for heard_word_packer: packing, timeout flush, backpressure, flush race, reset.
// Stats outputs are connected and checked when HEARD_PACKER_STATS_EN is defined.
module tb_heard_word_packer;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        heard_ena = 1'b0;
  logic        heard_rdy;
  logic [5:0]  heard_meth = '0;
  logic [3:0]  heard_v = '0;
  logic        word_ena;
  logic        word_rdy = 1'b0;
  logic [31:0] word_data;
`ifdef HEARD_PACKER_STATS_EN
  logic [15:0] stat_words;
  logic [15:0] stat_stall;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  heard_word_packer #(.METH_WIDTH(6), .V_WIDTH(4), .TIMEOUT(16)) dut (
    .CLK        (clk),
    .nRST       (nrst),
    .heard__ENA (heard_ena),
    .heard__RDY (heard_rdy),
    .heard_meth (heard_meth),
    .heard_v    (heard_v),
    .word__ENA  (word_ena),
    .word__RDY  (word_rdy),
    .word_data  (word_data)
`ifdef HEARD_PACKER_STATS_EN
    ,
    .stat_words (stat_words),
    .stat_stall (stat_stall)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    nrst = 1'b0;
    tick();
    nrst = 1'b1;
  endtask

  // Presents one entry, waiting (bounded) for heard__RDY before asserting heard__ENA.
  task automatic send(input logic [5:0] meth, input logic [3:0] v);
    int waited;
    waited = 0;
    heard_meth = meth;
    heard_v    = v;
    while (!heard_rdy && waited < 50) begin
      tick();
      waited++;
    end
    if (!heard_rdy) check("send_rdy_timeout", 32'(heard_rdy), 32'd1);
    heard_ena = 1'b1;
    tick();
    heard_ena = 1'b0;
  endtask

  task automatic wait_word(input int budget, output int n);
    n = 0;
    while (!word_ena && n < budget) begin
      tick();
      n++;
    end
  endtask

  task automatic count_words(input int cycles, output int c);
    c = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (word_ena) c++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int c;

    // Reset state
    tick();
    tick();
    check("rst_heard_rdy", 32'(heard_rdy), 32'd1);
    check("rst_word_ena", 32'(word_ena), 32'd0);
    check("rst_word_data", word_data, 32'h0);
    nrst = 1'b1;

    // Basic pack: slots 0x011, 0x022, 0x033 with count 3
    word_rdy = 1'b1;
    send(6'h01, 4'h1);
    send(6'h02, 4'h2);
    send(6'h03, 4'h3);
    check("basic_rdy_full", 32'(heard_rdy), 32'd0);
    check("basic_no_early_ena", 32'(word_ena), 32'd0);
    tick();
    check("basic_ena", 32'(word_ena), 32'd1);
    check("basic_data", word_data, 32'hC330_8811);
    count_words(6, c);
    check("basic_single_word", 32'(c), 32'd0);

    // Timeout flush of a single entry: 16 idle cycles then one load cycle
    send(6'h3F, 4'hF);
    wait_word(40, n);
    check("timeout_latency", 32'(n), 32'd17);
    check("timeout_data", word_data, 32'h4000_03FF);
    count_words(30, c);
    check("timeout_cnt_zero", 32'(c), 32'd0);
    check("timeout_rdy", 32'(heard_rdy), 32'd1);

    // Flush race: second entry arrives on the cycle idle reaches TIMEOUT
    send(6'h05, 4'h5);
    repeat (16) tick();
    send(6'h06, 4'h6);
    check("race_no_flush", 32'(word_ena), 32'd0);
    wait_word(40, n);
    check("race_latency", 32'(n), 32'd17);
    check("race_data_cnt2", word_data, 32'h8001_9855);
    tick();

    // Backpressure: one held word, a full accumulator, then two back-to-back words
    do_reset();
    word_rdy = 1'b0;
    send(6'h11, 4'h1);
    send(6'h12, 4'h2);
    send(6'h13, 4'h3);
    send(6'h21, 4'h4);
    send(6'h22, 4'h5);
    send(6'h23, 4'h6);
    check("bp_rdy_stalled", 32'(heard_rdy), 32'd0);
    check("bp_no_ena", 32'(word_ena), 32'd0);
    check("bp_held_word", word_data, 32'hD334_8911);
    repeat (5) tick();
    check("bp_still_stalled", 32'(heard_rdy), 32'd0);
    check("bp_still_held", word_data, 32'hD334_8911);
    word_rdy = 1'b1;
    #1;
    check("bp_word1_ena", 32'(word_ena), 32'd1);
    check("bp_word1_data", word_data, 32'hD334_8911);
    tick();
    check("bp_word2_ena", 32'(word_ena), 32'd1);
    check("bp_word2_data", word_data, 32'hE368_9614);
    tick();
    check("bp_drained", 32'(word_ena), 32'd0);
    check("bp_rdy_again", 32'(heard_rdy), 32'd1);
`ifdef HEARD_PACKER_STATS_EN
    check("stat_words", 32'(stat_words), 32'd2);
    check("stat_stall", 32'(stat_stall), 32'd5);
`endif

    // Reset mid-operation: word held and two entries accumulated
    word_rdy = 1'b0;
    send(6'h31, 4'h1);
    send(6'h32, 4'h2);
    send(6'h33, 4'h3);
    send(6'h34, 4'h4);
    send(6'h35, 4'h5);
    check("midrst_pre_rdy", 32'(heard_rdy), 32'd1);
    do_reset();
    check("midrst_rdy", 32'(heard_rdy), 32'd1);
    check("midrst_data", word_data, 32'h0);
    word_rdy = 1'b1;
    #1;
    check("midrst_no_valid", 32'(word_ena), 32'd0);
    count_words(40, c);
    check("midrst_no_stale", 32'(c), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
